// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter_pkg
//  Description : Shared master-ID constants, arbiter state encoding and a
//                small helper for the SRAM request arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_req_arbiter_pkg;

    // Master identifiers, also the value stored in the in-order ID FIFO
    localparam logic MID_INST = 1'b0;
    localparam logic MID_DATA = 1'b1;

    // Grant-lock state: IDLE arbitrates freely, LOCKx holds grant on master x
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // The master that is not 'mid'
    function automatic logic other_mid(input logic mid);
        return ~mid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sram_id_fifo
//  Description : In-order 1-bit master-ID FIFO. Pointers carry one extra
//                wrap bit so full and empty are distinguished without a
//                separate occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [DEPTH-1:0] r_mem;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    // Pointer advance and storage write; push ignored when full, pop when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wptr[AW-1:0]] <= i_din;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter
//  Description : Two-master (instruction / data) arbiter onto a single SRAM-
//                style slave. Round-robin with grant lock while a request is
//                stalled; responses are routed back in order via an ID FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-side master
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    // data-side master
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    // shared slave
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_prio;      // master that wins the next conflict
    logic       r_err;
    logic       w_grant;
    logic       w_greq;
    logic       w_accept;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;

    // Grant selection: a lock pins the grant, otherwise round-robin on conflict
    always_comb begin
        w_grant = r_prio;
        case (r_state)
            LOCK0:   w_grant = MID_INST;
            LOCK1:   w_grant = MID_DATA;
            default: begin
                if (m0_req && m1_req) w_grant = r_prio;
                else if (m1_req)      w_grant = MID_DATA;
                else if (m0_req)      w_grant = MID_INST;
                else                  w_grant = r_prio;
            end
        endcase
    end

    assign w_greq   = (w_grant == MID_DATA) ? m1_req : m0_req;
    // A full ID FIFO blocks new requests even if a pop happens this cycle
    assign s_req    = w_greq && !w_full && !reset;
    assign w_accept = s_req && s_addr_ok;

    assign s_wr     = (w_grant == MID_DATA) ? m1_wr    : m0_wr;
    assign s_size   = (w_grant == MID_DATA) ? m1_size  : m0_size;
    assign s_wstrb  = (w_grant == MID_DATA) ? m1_wstrb : m0_wstrb;
    assign s_addr   = (w_grant == MID_DATA) ? m1_addr  : m0_addr;
    assign s_wdata  = (w_grant == MID_DATA) ? m1_wdata : m0_wdata;

    assign m0_addr_ok = w_accept && (w_grant == MID_INST);
    assign m1_addr_ok = w_accept && (w_grant == MID_DATA);

    // Responses go to the master at the FIFO head with no added latency
    assign w_pop      = s_data_ok && !w_empty && !reset;
    assign m0_data_ok = w_pop && (w_head == MID_INST);
    assign m1_data_ok = w_pop && (w_head == MID_DATA);
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;

    assign err = r_err;

    // Lock state transitions: enter lock on a stalled request, leave on accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (s_req && !s_addr_ok)
                    w_state_nxt = (w_grant == MID_DATA) ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
                if (w_accept) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, round-robin pointer and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_prio  <= MID_DATA;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_prio <= other_mid(w_grant);
            if (s_data_ok && w_empty) r_err <= 1'b1;
        end
    end

    sram_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_accept),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_arbiter
//  Description : Directed self-checking bench for sram_req_arbiter.
//                Inputs change 1 time unit after the rising edge; outputs
//                are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;

    always #5 clk = ~clk;

    sram_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err(err)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_wstrb = 4'h0; m0_addr = A0; m0_wdata = '0;
        m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_wstrb = 4'h0; m1_addr = A1; m1_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
        end
        tick(); tick();
        idle_inputs(); reset = 0;
        @(negedge clk);
        n_cmp++;
        if ({err, s_req} !== 2'b00) begin
            n_err++; $display("FAIL reset_err_sreq: got %b want 00", {err, s_req});
        end
        tick();
    endtask

    task automatic test_both_read();
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok, m1_addr_ok} !== 3'b101 || s_addr !== A1) begin
            n_err++; $display("FAIL both_c0_m1_first: got ok=%b addr=%h want 101 addr=%h",
                              {s_req, m0_addr_ok, m1_addr_ok}, s_addr, A1);
        end
        tick(); m1_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({m0_addr_ok, m1_addr_ok} !== 2'b10 || s_addr !== A0) begin
            n_err++; $display("FAIL both_c1_m0: got ok=%b addr=%h want 10 addr=%h",
                              {m0_addr_ok, m1_addr_ok}, s_addr, A0);
        end
        tick(); m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hAAAA_0001;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b01 || m1_rdata !== 32'hAAAA_0001 || m0_rdata !== 32'h0) begin
            n_err++; $display("FAIL both_resp1_m1: got dok=%b r1=%h r0=%h want 01 AAAA0001 0",
                              {m0_data_ok, m1_data_ok}, m1_rdata, m0_rdata);
        end
        tick(); s_rdata = 32'hBBBB_0002;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b10 || m0_rdata !== 32'hBBBB_0002 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL both_resp2_m0: got dok=%b r0=%h r1=%h want 10 BBBB0002 0",
                              {m0_data_ok, m1_data_ok}, m0_rdata, m1_rdata);
        end
        tick(); idle_inputs();
    endtask

    task automatic test_lock();
        m0_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (s_req !== 1'b1 || s_addr !== A0 || {m0_addr_ok, m1_addr_ok} !== 2'b00) begin
                n_err++; $display("FAIL lock_hold_c%0d: got sreq=%b addr=%h ok=%b want 1 %h 00",
                                  c, s_req, s_addr, {m0_addr_ok, m1_addr_ok}, A0);
            end
            tick(); m1_req = 1;
        end
        s_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({m0_addr_ok, m1_addr_ok} !== 2'b10 || s_addr !== A0) begin
            n_err++; $display("FAIL lock_c3_m0: got ok=%b addr=%h want 10 %h",
                              {m0_addr_ok, m1_addr_ok}, s_addr, A0);
        end
        tick(); m0_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({m0_addr_ok, m1_addr_ok} !== 2'b01 || s_addr !== A1) begin
            n_err++; $display("FAIL lock_c4_m1: got ok=%b addr=%h want 01 %h",
                              {m0_addr_ok, m1_addr_ok}, s_addr, A1);
        end
        tick(); m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000_00C0;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b10 || m0_rdata !== 32'h0000_00C0) begin
            n_err++; $display("FAIL lock_resp_m0: got dok=%b r0=%h want 10 000000c0",
                              {m0_data_ok, m1_data_ok}, m0_rdata);
        end
        tick(); s_rdata = 32'h0000_00C1;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b01 || m1_rdata !== 32'h0000_00C1) begin
            n_err++; $display("FAIL lock_resp_m1: got dok=%b r1=%h want 01 000000c1",
                              {m0_data_ok, m1_data_ok}, m1_rdata);
        end
        tick(); idle_inputs();
    endtask

    task automatic test_full();
        m0_req = 1; s_addr_ok = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (m0_addr_ok !== 1'b1) begin
                n_err++; $display("FAIL full_accept_%0d: got %b want 1", c, m0_addr_ok);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok} !== 2'b00) begin
            n_err++; $display("FAIL full_block: got sreq/ok=%b want 00", {s_req, m0_addr_ok});
        end
        tick(); s_data_ok = 1; s_rdata = 32'h0000_0F00;
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok, m0_data_ok} !== 3'b001 || m0_rdata !== 32'h0000_0F00) begin
            n_err++; $display("FAIL full_pop_cycle: got sreq/ok/dok=%b r0=%h want 001 00000f00",
                              {s_req, m0_addr_ok, m0_data_ok}, m0_rdata);
        end
        tick(); s_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok} !== 2'b11) begin
            n_err++; $display("FAIL full_resume: got sreq/ok=%b want 11", {s_req, m0_addr_ok});
        end
        tick(); m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        for (int c = 0; c < 4; c++) begin
            s_rdata = 32'h0000_0F01 + c;
            @(negedge clk);
            n_cmp++;
            if ({m0_data_ok, m1_data_ok} !== 2'b10 || m0_rdata !== 32'h0000_0F01 + c) begin
                n_err++; $display("FAIL full_drain_%0d: got dok=%b r0=%h want 10 %h",
                                  c, {m0_data_ok, m1_data_ok}, m0_rdata, 32'h0000_0F01 + c);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_interleave();
        s_addr_ok = 1; m0_req = 1;
        tick(); m0_req = 0; m1_req = 1; m1_wr = 1; m1_wstrb = 4'b0110; m1_wdata = 32'hDEAD_BEEF; m1_size = 2'd1;
        @(negedge clk);
        n_cmp++;
        if ({m1_addr_ok, s_wr, s_wstrb, s_size} !== {1'b1, 1'b1, 4'b0110, 2'd1} || s_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL inter_m1_write_mux: got ok=%b wr=%b strb=%b size=%0d wdata=%h want 1 1 0110 1 deadbeef",
                              m1_addr_ok, s_wr, s_wstrb, s_size, s_wdata);
        end
        tick(); m1_req = 0; m1_wr = 0; m0_req = 1;
        tick(); m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        s_rdata = 32'h11;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b10 || m0_rdata !== 32'h11 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL inter_r1: got dok=%b r0=%h r1=%h want 10 11 0",
                              {m0_data_ok, m1_data_ok}, m0_rdata, m1_rdata);
        end
        tick(); s_rdata = 32'h22;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b01 || m1_rdata !== 32'h22 || m0_rdata !== 32'h0) begin
            n_err++; $display("FAIL inter_r2: got dok=%b r1=%h r0=%h want 01 22 0",
                              {m0_data_ok, m1_data_ok}, m1_rdata, m0_rdata);
        end
        tick(); s_rdata = 32'h33;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b10 || m0_rdata !== 32'h33) begin
            n_err++; $display("FAIL inter_r3: got dok=%b r0=%h want 10 33",
                              {m0_data_ok, m1_data_ok}, m0_rdata);
        end
        tick(); idle_inputs();
    endtask

    task automatic test_err();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_clean_before: got %b want 0", err);
        end
        tick(); s_data_ok = 1; s_rdata = 32'h5555_5555;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL err_no_dok: got dok=%b r0=%h r1=%h want 00 0 0",
                              {m0_data_ok, m1_data_ok}, m0_rdata, m1_rdata);
        end
        tick(); idle_inputs();
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: got %b want 1", err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // err is still set from the previous scenario; reset must clear it
        s_addr_ok = 1; m0_req = 1;
        tick(); tick(); tick();
        s_addr_ok = 0;  // fourth request stalls, locking the grant on m0
        tick();
        reset = 1;
        @(negedge clk);
        n_cmp++;
        if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 5'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got %b want 00000",
                              {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
        end
        tick(); reset = 0; m0_req = 1; m1_req = 1;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || s_addr !== A1 || {m0_addr_ok, m1_addr_ok} !== 2'b00) begin
            n_err++; $display("FAIL rstmid_idle_prio: got err=%b addr=%h ok=%b want 0 %h 00",
                              err, s_addr, {m0_addr_ok, m1_addr_ok}, A1);
        end
        reset = 1;
        tick(); idle_inputs(); reset = 0;
        tick(); s_data_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({m0_data_ok, m1_data_ok} !== 2'b00) begin
            n_err++; $display("FAIL rstmid_fifo_empty: got dok=%b want 00", {m0_data_ok, m1_data_ok});
        end
        tick(); s_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL rstmid_empty_err: got %b want 1", err);
        end
        reset = 1;
        tick(); reset = 0;
    endtask

    initial begin
        test_reset();
        test_both_read();
        test_lock();
        test_full();
        test_interleave();
        test_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
